// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store unit that splits a byte/half/word request into one or more beats
// on a MEM_BYTES-wide synchronous memory port, reassembles load data and
// sign/zero-extends it to 32 bits.
//
// Parameters:
//   MEM_BYTES  memory port width in bytes (1, 2 or 4)
//   ADDR_W     memory address width (>= 2)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid_i/req_ready_o  request handshake (ready only while idle)
//   req_we_i                 1 = store, 0 = load
//   req_size_i               00 byte, 01 half, 10/11 word
//   req_unsigned_i           zero-extend byte/half loads
//   req_addr_i, req_wdata_i  byte address, store data
//   rd_i                     destination tag, returned on rd_o
//   mem_ce_o/mem_we_o        beat valid / beat is a write
//   mem_addr_o, mem_be_o     beat address / lane enables
//   mem_wdata_o, mem_rdata_i write lanes / read lanes (read data one cycle
//                            after the beat that requested it)
//   done_o, rdata_o, rd_o    one-cycle completion with extended load result
//   err_o                    misaligned request (only with the check enabled)
//   stall_o                  NOT req_ready_o
//
// Build option:
//   MEM_MISALIGN_CHK_EN      when defined, misaligned requests complete at
//                            once with err_o = 1 and issue no beats
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int MEM_BYTES = 1,
  parameter int ADDR_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [1:0]             req_size_i,
  input  logic                   req_unsigned_i,
  input  logic [ADDR_W-1:0]      req_addr_i,
  input  logic [31:0]            req_wdata_i,
  input  logic [4:0]             rd_i,
  output logic                   mem_ce_o,
  output logic                   mem_we_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [MEM_BYTES-1:0]   mem_be_o,
  output logic [8*MEM_BYTES-1:0] mem_wdata_o,
  input  logic [8*MEM_BYTES-1:0] mem_rdata_i,
  output logic                   done_o,
  output logic [31:0]            rdata_o,
  output logic [4:0]             rd_o,
  output logic                   err_o,
  output logic                   stall_o
);

  localparam int MB_LOG = $clog2(MEM_BYTES);
  localparam int LANE_W = 8 * MEM_BYTES;
  localparam logic [31:0] LANE_MASK =
    (MEM_BYTES == 4) ? 32'hFFFF_FFFF : ((32'd1 << LANE_W) - 32'd1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       data_reg;
  logic [1:0]        size_reg;
  logic              unsigned_reg;
  logic              we_reg;
  logic [4:0]        rd_reg;
  logic [2:0]        beat_reg;

  logic              accept;
  logic [2:0]        size_bytes;
  logic [3:0]        size_mask;
  logic              narrow;
  logic [2:0]        n_beats;
  logic [1:0]        off;
  logic [ADDR_W-1:0] beat_addr;
  logic [31:0]       beat_wdata;
  logic [3:0]        narrow_be;
  logic              cap_en;
  logic [2:0]        cap_idx;
  logic [5:0]        cap_pos;
  logic [31:0]       lane_data;
  logic [31:0]       load_ext;
  logic              err_flag;

  assign accept = (state_reg == IDLE) && req_valid_i;

  // Latched size is already folded so that 11 behaves as a word.
  assign size_bytes = (size_reg == 2'b00) ? 3'd1 : (size_reg == 2'b01) ? 3'd2 : 3'd4;
  assign size_mask  = (size_reg == 2'b00) ? 4'b0001 : (size_reg == 2'b01) ? 4'b0011 : 4'b1111;
  assign narrow     = ({29'd0, size_bytes} < 32'(MEM_BYTES));
  assign n_beats    = narrow ? 3'd1 : (size_bytes >> MB_LOG);

  // Lane offset of the address inside one memory word (always 0 for byte ports).
  assign off = addr_reg[1:0] & 2'(MEM_BYTES - 1);

`ifdef MEM_MISALIGN_CHK_EN
  logic misaligned;
  logic err_reg;

  always_comb begin
    misaligned = 1'b0;
    case (req_size_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr_i[0];
      default: misaligned = |req_addr_i[1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (accept) begin
      err_reg <= misaligned;
    end
  end

  assign err_flag = err_reg;
`else
  assign err_flag = 1'b0;
`endif

  // Beat address, data and lane enables for the current beat.
  assign beat_addr  = narrow ? (addr_reg & ~ADDR_W'(MEM_BYTES - 1))
                             : (addr_reg + (ADDR_W'(beat_reg) << MB_LOG));
  assign beat_wdata = narrow ? (wdata_reg << {off, 3'b000})
                             : (wdata_reg >> (6'(beat_reg) << (3 + MB_LOG)));
  assign narrow_be  = size_mask << off;

  // Read data for beat k arrives while beat k+1 is on the bus (or in DRAIN
  // for the last beat), so the capture index trails the issue index by one.
  assign cap_en    = !we_reg && (((state_reg == ISSUE) && (beat_reg != 3'd0)) ||
                                 (state_reg == DRAIN));
  assign cap_idx   = (state_reg == DRAIN) ? (n_beats - 3'd1) : (beat_reg - 3'd1);
  assign cap_pos   = 6'(cap_idx) << (3 + MB_LOG);
  assign lane_data = narrow ? (32'(mem_rdata_i) >> {off, 3'b000}) : 32'(mem_rdata_i);

  always_comb begin
    load_ext = data_reg;
    case (size_reg)
      2'b00:   load_ext = unsigned_reg ? {24'd0, data_reg[7:0]}
                                       : {{24{data_reg[7]}}, data_reg[7:0]};
      2'b01:   load_ext = unsigned_reg ? {16'd0, data_reg[15:0]}
                                       : {{16{data_reg[15]}}, data_reg[15:0]};
      default: load_ext = data_reg;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid_i) begin
`ifdef MEM_MISALIGN_CHK_EN
          state_next = misaligned ? DONE : ISSUE;
`else
          state_next = ISSUE;
`endif
        end
      end
      ISSUE: begin
        if (beat_reg == (n_beats - 3'd1)) begin
          state_next = we_reg ? DONE : DRAIN;
        end
      end
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, beat counter and load assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg     <= '0;
      wdata_reg    <= '0;
      data_reg     <= '0;
      size_reg     <= '0;
      unsigned_reg <= 1'b0;
      we_reg       <= 1'b0;
      rd_reg       <= '0;
      beat_reg     <= '0;
    end else begin
      if (accept) begin
        addr_reg     <= req_addr_i;
        wdata_reg    <= req_wdata_i;
        size_reg     <= (req_size_i == 2'b11) ? 2'b10 : req_size_i;
        unsigned_reg <= req_unsigned_i;
        we_reg       <= req_we_i;
        rd_reg       <= rd_i;
        beat_reg     <= '0;
      end else if (state_reg == ISSUE) begin
        beat_reg <= beat_reg + 3'd1;
      end
      if (cap_en) begin
        data_reg <= (data_reg & ~(LANE_MASK << cap_pos)) |
                    ((lane_data & LANE_MASK) << cap_pos);
      end
    end
  end

  // Outputs are decoded from the state so reset clears them immediately.
  always_comb begin
    req_ready_o = (state_reg == IDLE);
    stall_o     = (state_reg != IDLE);
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    done_o      = 1'b0;
    rdata_o     = '0;
    rd_o        = '0;
    err_o       = 1'b0;
    if (state_reg == ISSUE) begin
      mem_ce_o    = 1'b1;
      mem_we_o    = we_reg;
      mem_addr_o  = beat_addr;
      mem_be_o    = narrow ? narrow_be[MEM_BYTES-1:0] : '1;
      mem_wdata_o = beat_wdata[LANE_W-1:0];
    end
    if (state_reg == DONE) begin
      done_o  = 1'b1;
      rd_o    = rd_reg;
      err_o   = err_flag;
      rdata_o = (we_reg || err_flag) ? 32'd0 : load_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Three instances (MEM_BYTES = 1, 2, 4) share one request stream and each has
// its own byte-addressed synchronous memory model. Directed transactions are
// checked cycle by cycle against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  rd;

  logic        r1_ready, r1_ce, r1_we, r1_done, r1_err, r1_stall;
  logic [31:0] r1_addr, r1_rdata;
  logic [0:0]  r1_be;
  logic [7:0]  r1_wdata, r1_mrd;
  logic [4:0]  r1_rd;

  logic        r2_ready, r2_ce, r2_we, r2_done, r2_err, r2_stall;
  logic [31:0] r2_addr, r2_rdata;
  logic [1:0]  r2_be;
  logic [15:0] r2_wdata, r2_mrd;
  logic [4:0]  r2_rd;

  logic        r4_ready, r4_ce, r4_we, r4_done, r4_err, r4_stall;
  logic [31:0] r4_addr, r4_rdata;
  logic [3:0]  r4_be;
  logic [31:0] r4_wdata, r4_mrd;
  logic [4:0]  r4_rd;

  mem_access_unit #(.MEM_BYTES(1), .ADDR_W(32)) dut1 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(r1_ready),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rd_i(rd),
    .mem_ce_o(r1_ce), .mem_we_o(r1_we), .mem_addr_o(r1_addr), .mem_be_o(r1_be),
    .mem_wdata_o(r1_wdata), .mem_rdata_i(r1_mrd), .done_o(r1_done),
    .rdata_o(r1_rdata), .rd_o(r1_rd), .err_o(r1_err), .stall_o(r1_stall));

  mem_access_unit #(.MEM_BYTES(2), .ADDR_W(32)) dut2 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(r2_ready),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rd_i(rd),
    .mem_ce_o(r2_ce), .mem_we_o(r2_we), .mem_addr_o(r2_addr), .mem_be_o(r2_be),
    .mem_wdata_o(r2_wdata), .mem_rdata_i(r2_mrd), .done_o(r2_done),
    .rdata_o(r2_rdata), .rd_o(r2_rd), .err_o(r2_err), .stall_o(r2_stall));

  mem_access_unit #(.MEM_BYTES(4), .ADDR_W(32)) dut4 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(r4_ready),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rd_i(rd),
    .mem_ce_o(r4_ce), .mem_we_o(r4_we), .mem_addr_o(r4_addr), .mem_be_o(r4_be),
    .mem_wdata_o(r4_wdata), .mem_rdata_i(r4_mrd), .done_o(r4_done),
    .rdata_o(r4_rdata), .rd_o(r4_rd), .err_o(r4_err), .stall_o(r4_stall));

  // Memory models: preload port plus one synchronous read/write port each.
  logic [7:0]  m1 [0:4095];
  logic [7:0]  m2 [0:4095];
  logic [7:0]  m4 [0:4095];
  logic        pl_en = 1'b0;
  logic [1:0]  pl_sel = 2'd0;
  logic [11:0] pl_addr = 12'd0;
  logic [7:0]  pl_data = 8'd0;

  always @(posedge clk) begin
    if (pl_en && pl_sel == 2'd0) m1[pl_addr] <= pl_data;
    if (r1_ce) begin
      if (r1_we) begin
        if (r1_be[0]) m1[r1_addr[11:0]] <= r1_wdata;
      end else begin
        r1_mrd <= m1[r1_addr[11:0]];
      end
    end
  end

  always @(posedge clk) begin
    if (pl_en && pl_sel == 2'd1) m2[pl_addr] <= pl_data;
    if (r2_ce) begin
      for (int i = 0; i < 2; i++) begin
        if (r2_we) begin
          if (r2_be[i]) m2[r2_addr[11:0] + 12'(i)] <= r2_wdata[8*i +: 8];
        end else begin
          r2_mrd[8*i +: 8] <= m2[r2_addr[11:0] + 12'(i)];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (pl_en && pl_sel == 2'd2) m4[pl_addr] <= pl_data;
    if (r4_ce) begin
      for (int j = 0; j < 4; j++) begin
        if (r4_we) begin
          if (r4_be[j]) m4[r4_addr[11:0] + 12'(j)] <= r4_wdata[8*j +: 8];
        end else begin
          r4_mrd[8*j +: 8] <= m4[r4_addr[11:0] + 12'(j)];
        end
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [1:0] sel, input logic [11:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_sel = sel; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Present one request in IDLE; returns in cycle 1 with the request inputs
  // scrambled so that only the latched copy can be in use.
  task automatic start(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] tag);
    $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h rd=%0d",
             we, size, uns, addr, wdata, tag);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; rd = tag; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_we = ~we; req_size = 2'b00; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0BAD_F00D; rd = 5'd31;
  endtask

  // MEM_BYTES = 1 load with n beats: first beat, done latency, result.
  task automatic load1(input string tag, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input int n, input logic [31:0] exp);
    start(1'b0, size, uns, addr, 32'h0, 5'd5);
    check({tag, " ce c1"}, r1_ce, 1'b1);
    check({tag, " we c1"}, r1_we, 1'b0);
    check({tag, " addr c1"}, r1_addr, addr);
    repeat (n) tick();
    check({tag, " early done"}, r1_done, 1'b0);
    tick();
    check({tag, " done"}, r1_done, 1'b1);
    check({tag, " rdata"}, r1_rdata, exp);
    check({tag, " rd"}, r1_rd, 5'd5);
    tick();
  endtask

  logic [7:0] sw_bytes [4];

  initial begin
    sw_bytes = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rd = 5'd0;
    rst = 1'b1;

    // Preload while in reset
    poke(2'd0, 12'h200, 8'h80);
    poke(2'd0, 12'h202, 8'h01);
    poke(2'd0, 12'h203, 8'h80);
    poke(2'd0, 12'h104, 8'h55);
    poke(2'd0, 12'h500, 8'h00);
    poke(2'd0, 12'h501, 8'h00);
    poke(2'd0, 12'h502, 8'h00);
    poke(2'd1, 12'h400, 8'h78);
    poke(2'd1, 12'h401, 8'h56);
    poke(2'd1, 12'h402, 8'h34);
    poke(2'd1, 12'h403, 8'h12);
    poke(2'd2, 12'h300, 8'h34);
    poke(2'd2, 12'h301, 8'h12);
    poke(2'd2, 12'h302, 8'hBC);
    poke(2'd2, 12'h303, 8'h9A);

    check("rst ready", r1_ready, 1'b1);
    check("rst stall", r1_stall, 1'b0);
    check("rst ce", r1_ce, 1'b0);
    check("rst done", r1_done, 1'b0);
    check("rst rdata", r1_rdata, 32'h0);
    check("rst err", r1_err, 1'b0);
    check("rst ready4", r4_ready, 1'b1);
    rst = 1'b0;
    tick();

    // SW 0x100 on the byte port: four beats then done in cycle 5
    start(1'b1, 2'b10, 1'b0, 32'h100, 32'hA1B2C3D4, 5'd3);
    check("sw ready c1", r1_ready, 1'b0);
    check("sw stall c1", r1_stall, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sw ce b%0d", k), r1_ce, 1'b1);
      check($sformatf("sw we b%0d", k), r1_we, 1'b1);
      check($sformatf("sw addr b%0d", k), r1_addr, 32'h100 + 32'(k));
      check($sformatf("sw wdata b%0d", k), r1_wdata, sw_bytes[k]);
      check($sformatf("sw be b%0d", k), r1_be, 1'b1);
      check($sformatf("sw done b%0d", k), r1_done, 1'b0);
      tick();
    end
    check("sw done c5", r1_done, 1'b1);
    check("sw rd", r1_rd, 5'd3);
    check("sw rdata", r1_rdata, 32'h0);
    check("sw ce c5", r1_ce, 1'b0);
    tick();
    check("sw ready c6", r1_ready, 1'b1);
    check("sw done c6", r1_done, 1'b0);
    check("sw mem 103", m1[12'h103], 8'hA1);
    tick();

    // Byte-port loads
    load1("lb", 2'b00, 1'b0, 32'h200, 1, 32'hFFFF_FF80);
    load1("lbu", 2'b00, 1'b1, 32'h200, 1, 32'h0000_0080);
    load1("lh", 2'b01, 1'b0, 32'h202, 2, 32'hFFFF_8001);
    load1("lhu", 2'b01, 1'b1, 32'h202, 2, 32'h0000_8001);
    load1("lw sz11", 2'b11, 1'b1, 32'h100, 4, 32'hA1B2_C3D4);
    repeat (2) tick();

`ifdef MEM_MISALIGN_CHK_EN
    start(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd6);
    check("mis ce", r1_ce, 1'b0);
    check("mis done", r1_done, 1'b1);
    check("mis err", r1_err, 1'b1);
    check("mis rdata", r1_rdata, 32'h0);
    check("mis ce4", r4_ce, 1'b0);
    tick();
    check("mis ready", r1_ready, 1'b1);
    repeat (2) tick();
`else
    load1("lw mis", 2'b10, 1'b0, 32'h101, 4, 32'h55A1_B2C3);
    check("mis err tied", r1_err, 1'b0);
    repeat (2) tick();
`endif

    // LW on the half port: two beats, done in cycle 4
    start(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd8);
    check("lw2 addr b0", r2_addr, 32'h400);
    check("lw2 be b0", r2_be, 2'b11);
    tick();
    check("lw2 addr b1", r2_addr, 32'h402);
    check("lw2 ce b1", r2_ce, 1'b1);
    tick();
    check("lw2 early done", r2_done, 1'b0);
    tick();
    check("lw2 done", r2_done, 1'b1);
    check("lw2 rdata", r2_rdata, 32'h1234_5678);
    check("lw2 rd", r2_rd, 5'd8);
    repeat (4) tick();

    // SB on the half port at an odd address: upper lane only
    start(1'b1, 2'b00, 1'b0, 32'h405, 32'h1234_56EE, 5'd2);
    check("sb2 addr", r2_addr, 32'h404);
    check("sb2 be", r2_be, 2'b10);
    check("sb2 wdata", r2_wdata, 16'hEE00);
    tick();
    check("sb2 done", r2_done, 1'b1);
    check("sb2 mem", m2[12'h405], 8'hEE);
    repeat (3) tick();

    // LH on the word port at 0x302: one narrow beat, done in cycle 3
    start(1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 5'd4);
    check("lh4 addr", r4_addr, 32'h300);
    check("lh4 be", r4_be, 4'b1100);
    tick();
    check("lh4 ce c2", r4_ce, 1'b0);
    tick();
    check("lh4 done", r4_done, 1'b1);
    check("lh4 rdata", r4_rdata, 32'hFFFF_9ABC);
    repeat (4) tick();

    // SW on the word port: single full beat, done in cycle 2
    start(1'b1, 2'b10, 1'b0, 32'h308, 32'hCAFE_F00D, 5'd1);
    check("sw4 be", r4_be, 4'b1111);
    check("sw4 wdata", r4_wdata, 32'hCAFE_F00D);
    check("sw4 addr", r4_addr, 32'h308);
    tick();
    check("sw4 done", r4_done, 1'b1);
    repeat (5) tick();

    // Reset in cycle 2 of an SW: beat 1 dropped, no completion
    start(1'b1, 2'b10, 1'b0, 32'h500, 32'h1122_3344, 5'd9);
    tick();
    check("rsw ce c2", r1_ce, 1'b1);
    check("rsw addr c2", r1_addr, 32'h501);
    rst = 1'b1;
    #1;
    check("rsw ce rst", r1_ce, 1'b0);
    check("rsw ready rst", r1_ready, 1'b1);
    check("rsw done rst", r1_done, 1'b0);
    check("rsw stall rst", r1_stall, 1'b0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("rsw no done %0d", c), r1_done, 1'b0);
      check($sformatf("rsw no ce %0d", c), r1_ce, 1'b0);
      tick();
    end
    check("rsw ready after", r1_ready, 1'b1);
    check("rsw mem 500", m1[12'h500], 8'h44);
    check("rsw mem 501", m1[12'h501], 8'h00);
    check("rsw mem 502", m1[12'h502], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
